// File: rtl/rate_pkg.sv
// Shared constants, FSM state type and the period helper for the rate pulse generator.
package rate_pkg;

  // Rate-select encodings on the speed switches
  localparam logic [1:0] SPD_FAST    = 2'b00;
  localparam logic [1:0] SPD_1HZ     = 2'b01;
  localparam logic [1:0] SPD_HALF    = 2'b10;
  localparam logic [1:0] SPD_QUARTER = 2'b11;

  typedef enum logic [0:0] {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } state_e;

  // Period minus one for a given rate; callers truncate to their counter width.
  function automatic logic [31:0] period_m1(logic [1:0] speed, int unsigned clk_freq);
    logic [31:0] freq;
    logic [31:0] result;
    freq = 32'(clk_freq);
    case (speed)
      SPD_FAST: result = 32'd0;
      SPD_1HZ:  result = freq - 32'd1;
      SPD_HALF: result = (freq << 1) - 32'd1;
      default:  result = (freq << 2) - 32'd1;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/step_sync.sv
// Two-flop synchronizer for the step button followed by a rising-edge detector.
module step_sync (
  input  logic clock,
  input  logic resetn,
  input  logic async_in,
  output logic pulse
);

  logic sync1_q;
  logic sync2_q;
  logic edge_q;

  // Synchronizer chain plus the delayed copy used for edge detection
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  // High for one cycle per press regardless of hold length
  assign pulse = sync2_q & ~edge_q;

endmodule

// File: rtl/rate_pulse_gen.sv
// Produces single-cycle enable pulses at a switch-selected rate, with pause/run and
// single-step support, for driving the downstream counter's Enable input.
module rate_pulse_gen
  import rate_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned CNT_WIDTH = 28
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] speed,
  input  logic       run,
  input  logic       step,
  output logic       enable_out,
  output logic       running
);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   reload;
  logic [1:0]             speed_q;
  logic                   enable_q, enable_d;
  logic                   step_pulse;
  logic                   speed_chg;
  logic                   terminal;

  step_sync u_step_sync (
    .clock    (clock),
    .resetn   (resetn),
    .async_in (step),
    .pulse    (step_pulse)
  );

  // Reload always uses the live speed so a change takes effect on the first edge
  assign reload    = CNT_WIDTH'(period_m1(speed, CLK_FREQ));
  assign speed_chg = (speed != speed_q);
  assign terminal  = (cnt_q == '0);

  // Next-state: run level drives the FSM; counter reloads, decrements or holds
  always_comb begin
    state_d  = run ? RUNNING : PAUSED;
    cnt_d    = cnt_q;
    enable_d = 1'b0;
    if (state_q == RUNNING) begin
      if (speed_chg) begin
        // A terminal count coinciding with a rate change is swallowed
        cnt_d = reload;
      end else if (terminal) begin
        // Leaving RUNNING on a terminal count reloads but emits nothing
        cnt_d    = reload;
        enable_d = run;
      end else if (run) begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
      end
    end else begin
      if (run || speed_chg) begin
        cnt_d = reload;
      end
      // A step edge landing on the run-rising cycle is dropped
      enable_d = step_pulse & ~run;
    end
  end

  // State, counter, registered speed copy and the output pulse register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= PAUSED;
      cnt_q    <= '0;
      speed_q  <= speed;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      speed_q  <= speed;
      enable_q <= enable_d;
    end
  end

  assign enable_out = enable_q;
  assign running    = (state_q == RUNNING);

endmodule

// File: tb/tb_rate_pulse_gen.sv
// Directed bench for rate_pulse_gen: stimulus queues expected pulse cycles, a monitor
// compares every observed pulse (and the running flag) against them.
module tb_rate_pulse_gen;

  logic       clock = 1'b0;
  logic       resetn;
  logic       run;
  logic       step;
  logic [1:0] speed;
  logic       enable_out;
  logic       running;

  int   cyc       = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   exp_q[$];
  logic mon_en    = 1'b0;
  logic run_model = 1'b0;

  rate_pulse_gen #(
    .CLK_FREQ  (4),
    .CNT_WIDTH (5)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .speed      (speed),
    .run        (run),
    .step       (step),
    .enable_out (enable_out),
    .running    (running)
  );

  always #5 clock = ~clock;

  // Edge count and the expected running flag (run sampled, forced low in reset)
  always @(posedge clock) begin
    cyc       <= cyc + 1;
    run_model <= resetn ? run : 1'b0;
  end

  // Monitor: compares outputs at the falling edge against the scoreboard
  always @(negedge clock) begin
    int e;
    if (mon_en) begin
      checks = checks + 1;
      if (running !== run_model) begin
        errors = errors + 1;
        $display("FAIL running cyc=%0d got=%b want=%b", cyc, running, run_model);
      end
      if (enable_out === 1'b1) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL stray_pulse cyc=%0d got=1 want=0", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e != cyc) begin
            errors = errors + 1;
            $display("FAIL pulse_time got cyc=%0d want cyc=%0d", cyc, e);
          end
        end
      end else if (enable_out !== 1'b0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL enable_unknown cyc=%0d got=%b want=0/1", cyc, enable_out);
      end else if (exp_q.size() != 0 && exp_q[0] <= cyc) begin
        checks = checks + 1;
        errors = errors + 1;
        e = exp_q.pop_front();
        $display("FAIL missed_pulse cyc=%0d got=0 want pulse at cyc=%0d", cyc, e);
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Queue n pulses spaced p cycles apart, the first p cycles after edge e
  task automatic push_train(input int e, input int p, input int n);
    for (int k = 1; k <= n; k++) exp_q.push_back(e + p * k);
  endtask

  initial begin
    int e;
    int c;
    resetn = 1'b0;
    run    = 1'b1;
    speed  = 2'b01;
    step   = 1'b0;
    wait_n(1);
    mon_en = 1'b1;
    wait_n(2);

    // Reset release with run held: running next cycle, pulse 4 cycles later
    resetn = 1'b1;
    e = cyc + 1;
    push_train(e, 4, 2);
    wait_n(9);

    // Speed 00: every cycle; changing on the 5th would-be pulse suppresses it
    speed = 2'b00;
    e = cyc + 1;
    push_train(e, 1, 4);
    wait_n(5);

    // Speed 10: spacing 8
    speed = 2'b10;
    e = cyc + 1;
    push_train(e, 8, 2);
    wait_n(17);

    // Speed 11: spacing 16, then switch to 01 with cnt==2
    speed = 2'b11;
    e = cyc + 1;
    push_train(e, 16, 1);
    wait_n(30);
    speed = 2'b01;
    e = cyc + 1;
    push_train(e, 4, 2);
    wait_n(10);

    // Drop run at cnt==2 for 5 cycles, then resume
    run = 1'b0;
    wait_n(5);
    run = 1'b1;
    e = cyc + 1;
    push_train(e, 4, 1);
    wait_n(8);
    // Run falls exactly on the terminal count: no pulse
    run = 1'b0;
    wait_n(3);

    // Step held 10 cycles while paused: one pulse, 3 edges later
    step = 1'b1;
    c = cyc;
    exp_q.push_back(c + 3);
    wait_n(10);
    step = 1'b0;
    wait_n(4);

    // Step pressed while running: ignored
    run  = 1'b1;
    step = 1'b1;
    e = cyc + 1;
    push_train(e, 4, 2);
    wait_n(10);
    step = 1'b0;
    run  = 1'b0;
    wait_n(6);

    // Step edge on the same cycle run rises: dropped
    step = 1'b1;
    wait_n(2);
    run = 1'b1;
    e = cyc + 1;
    push_train(e, 4, 1);
    wait_n(6);
    run  = 1'b0;
    step = 1'b0;
    wait_n(4);

    // Reset mid-period at speed 10: nothing after, run held low
    speed = 2'b10;
    run   = 1'b1;
    e = cyc + 1;
    push_train(e, 8, 1);
    wait_n(11);
    resetn = 1'b0;
    run    = 1'b0;
    wait_n(2);
    resetn = 1'b1;
    wait_n(20);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
